// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// Prioritised external interrupt controller feeding coprocessor 0, with an mtc0-style register port.
// o_irq rises one cycle after a line is captured; ack/eret take effect on the sampling edge; no backpressure.
module irq_controller #(
  parameter int         N_IRQ        = 8,
  parameter logic [4:0] PENDING_ADDR = 5'd0,
  parameter logic [4:0] MASK_ADDR    = 5'd1,
  parameter logic [4:0] TRIGGER_ADDR = 5'd2,
  parameter logic [4:0] VECTOR_ADDR  = 5'd3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_ack,
  input  logic             i_eret,
  input  logic             i_we,
  input  logic [4:0]       i_address,
  input  logic [31:0]      i_data,
  output logic             o_irq,
  output logic [4:0]       o_vector,
  output logic [31:0]      o_data
);

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] trigger;
  logic [N_IRQ-1:0] irq_prev;
  logic             in_service;
  logic [4:0]       vector;

  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] set_bits;
  logic [N_IRQ-1:0] clr_bits;
  logic [N_IRQ-1:0] ack_sel;
  logic [4:0]       ack_idx;
  logic             ack_eff;
  logic             pend_wr;
  logic             mask_wr;
  logic             trig_wr;
  logic             unused_data;

  // Edge-mode lines set only on a 0->1 transition; level-mode lines set whenever high.
  assign set_bits = i_irq & (~trigger | ~irq_prev);
  assign req      = pending & mask;
  assign o_irq    = (|req) & ~in_service;
  assign ack_eff  = i_ack & o_irq;
  assign o_vector = vector;

  assign pend_wr = i_we && (i_address == PENDING_ADDR);
  assign mask_wr = i_we && (i_address == MASK_ADDR);
  assign trig_wr = i_we && (i_address == TRIGGER_ADDR);

  assign unused_data = ^i_data;

  // Scan high to low so the lowest requesting index wins.
  always_comb begin
    ack_idx = '0;
    ack_sel = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        ack_idx    = 5'(k);
        ack_sel    = '0;
        ack_sel[k] = 1'b1;
      end
    end
  end

  assign clr_bits = ({N_IRQ{pend_wr}} & i_data[N_IRQ-1:0])
                  | ({N_IRQ{ack_eff}} & ack_sel);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending    <= '0;
      mask       <= '0;
      trigger    <= '0;
      irq_prev   <= '0;
      in_service <= 1'b0;
      vector     <= '0;
    end else begin
      irq_prev <= i_irq;
      pending  <= (pending & ~clr_bits) | set_bits;
      if (mask_wr) mask <= i_data[N_IRQ-1:0];
      if (trig_wr) trigger <= i_data[N_IRQ-1:0];
      // An effective ack implies in_service was 0, so it also wins over a coincident eret.
      if (ack_eff) begin
        in_service <= 1'b1;
        vector     <= ack_idx;
      end else if (i_eret) begin
        in_service <= 1'b0;
      end
    end
  end

  always_comb begin
    o_data = '0;
    case (i_address)
      PENDING_ADDR: o_data[N_IRQ-1:0] = pending;
      MASK_ADDR:    o_data[N_IRQ-1:0] = mask;
      TRIGGER_ADDR: o_data[N_IRQ-1:0] = trigger;
      VECTOR_ADDR:  o_data = {in_service, 26'b0, vector};
      default:      o_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
// Directed self-checking bench for irq_controller.
module tb_irq_controller;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_irq;
  logic        i_ack;
  logic        i_eret;
  logic        i_we;
  logic [4:0]  i_address;
  logic [31:0] i_data;
  logic        o_irq;
  logic [4:0]  o_vector;
  logic [31:0] o_data;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] A_PEND = 5'd0;
  localparam logic [4:0] A_MASK = 5'd1;
  localparam logic [4:0] A_TRIG = 5'd2;
  localparam logic [4:0] A_VEC  = 5'd3;

  irq_controller dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_irq     (i_irq),
    .i_ack     (i_ack),
    .i_eret    (i_eret),
    .i_we      (i_we),
    .i_address (i_address),
    .i_data    (i_data),
    .o_irq     (o_irq),
    .o_vector  (o_vector),
    .o_data    (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    i_address = addr;
    #1;
    check(tag, o_data, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    i_we      = 1'b1;
    i_address = addr;
    i_data    = data;
    tick();
    i_we   = 1'b0;
    i_data = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_irq = '0; i_ack = 0; i_eret = 0;
    i_we = 0; i_address = '0; i_data = '0;
    #2;
    check("rst_irq", {31'b0, o_irq}, 32'd0);
    check("rst_vector", {27'b0, o_vector}, 32'd0);
    chk_rd("rst_pend", A_PEND, 32'h0);
    chk_rd("rst_mask", A_MASK, 32'h0);
    chk_rd("rst_trig", A_TRIG, 32'h0);
    chk_rd("rst_vec",  A_VEC,  32'h0);

    // Idle with everything masked: lines latch in level mode but never request.
    tick();
    i_rst = 1'b0;
    i_irq = 8'hFF;
    tick();
    tick();
    check("masked_irq", {31'b0, o_irq}, 32'd0);
    chk_rd("masked_pend", A_PEND, 32'hFF);
    i_irq = 8'h00;
    wr(A_PEND, 32'hFF);
    chk_rd("w1c_pend", A_PEND, 32'h0);

    wr(A_MASK, 32'hFF);
    wr(A_TRIG, 32'hFF);
    chk_rd("mask_rd", A_MASK, 32'hFF);
    chk_rd("trig_rd", A_TRIG, 32'hFF);

    // Priority: lines 5 and 2 together, lowest index served first.
    i_irq = 8'h24;
    tick();
    i_irq = 8'h00;
    check("prio_req", {31'b0, o_irq}, 32'd1);
    chk_rd("prio_pend", A_PEND, 32'h24);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("prio_vec1", {27'b0, o_vector}, 32'd2);
    check("prio_irq_off", {31'b0, o_irq}, 32'd0);
    chk_rd("prio_pend2", A_PEND, 32'h20);
    chk_rd("prio_status", A_VEC, 32'h8000_0002);
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("b2b_req", {31'b0, o_irq}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("prio_vec2", {27'b0, o_vector}, 32'd5);
    check("prio_irq_off2", {31'b0, o_irq}, 32'd0);
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("idle_after", {31'b0, o_irq}, 32'd0);

    // Edge mode: line 3 held high is serviced once.
    i_irq = 8'h08;
    tick();
    check("edge_req", {31'b0, o_irq}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("edge_vec", {27'b0, o_vector}, 32'd3);
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("edge_norereq", {31'b0, o_irq}, 32'd0);
    tick();
    check("edge_norereq2", {31'b0, o_irq}, 32'd0);
    chk_rd("edge_pend", A_PEND, 32'h0);

    // Level mode: the same held line keeps requesting.
    wr(A_TRIG, 32'h00);
    tick();
    check("level_req", {31'b0, o_irq}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("level_ack_irq", {31'b0, o_irq}, 32'd0);
    check("level_vec", {27'b0, o_vector}, 32'd3);
    chk_rd("level_pend_held", A_PEND, 32'h08);
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("level_rereq", {31'b0, o_irq}, 32'd1);
    i_irq = 8'h00;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("level_done_irq", {31'b0, o_irq}, 32'd0);
    chk_rd("level_done_pend", A_PEND, 32'h0);

    // Set beats write-1-to-clear on the same edge.
    wr(A_TRIG, 32'hFF);
    i_we = 1'b1; i_address = A_PEND; i_data = 32'h1;
    i_irq = 8'h01;
    tick();
    i_we = 1'b0; i_data = '0;
    chk_rd("set_beats_clr", A_PEND, 32'h01);

    // Ack gating: a second ack while in service must not move the vector.
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk_rd("gate_status0", A_VEC, 32'h8000_0000);
    i_irq = 8'h41;
    tick();
    check("gate_irq_low", {31'b0, o_irq}, 32'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk_rd("gate_status1", A_VEC, 32'h8000_0000);
    chk_rd("gate_pend", A_PEND, 32'h40);
    i_eret = 1'b1;
    tick();
    i_eret = 1'b0;
    check("gate_rereq", {31'b0, o_irq}, 32'd1);
    i_ack = 1'b1; i_eret = 1'b1;
    tick();
    i_ack = 1'b0; i_eret = 1'b0;
    chk_rd("ack_eret_status", A_VEC, 32'h8000_0006);
    check("ack_eret_irq", {31'b0, o_irq}, 32'd0);
    chk_rd("ack_eret_pend", A_PEND, 32'h0);

    // Async reset between edges while in service with a line pending.
    i_irq = 8'h43;
    tick();
    chk_rd("pre_rst_pend", A_PEND, 32'h02);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_irq", {31'b0, o_irq}, 32'd0);
    chk_rd("arst_vec", A_VEC, 32'h0);
    chk_rd("arst_mask", A_MASK, 32'h0);
    chk_rd("arst_pend", A_PEND, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
